// File: rtl/fadd_sched_if.sv
// fadd_sched_if: requester-side bundle for fadd_sched.
//   req_valid/req_ready  per-requester issue handshake (2 lanes)
//   req_op1/req_op2      IEEE-754 single operands, lane i in bits [32i+31:32i]
//   req_sub              per-lane subtract request
//   resp_valid/ready     per-lane result handshake
//   resp_data            per-lane result FIFO head, same packing
// master = requesters, slave = scheduler.
interface fadd_sched_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_op1;
  logic [63:0] req_op2;
  logic [1:0]  req_sub;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [63:0] resp_data;

  modport master (
    output req_valid, req_op1, req_op2, req_sub, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_sub, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/fadd_sched.sv
// fadd_sched: shares one fixed-latency fadd pipeline between two requesters.
// Round-robin arbitration, credit-based issue against per-requester result
// FIFOs, in-flight owner tracking and in-order result return per requester.
// Ports:
//   clk          single clock (fadd runs on it too)
//   reset        asynchronous, active-low
//   rq           requester bundle (fadd_sched_if.slave)
//   fadd_op1/2   operands to the adder, 0 when nothing is granted
//   fadd_result  adder result register output
// Parameters: LAT (adder latency, edges), DEPTH (FIFO entries, power of two >= 2)
// Optional: define FADD_SCHED_SUB_EN to honour req_sub by flipping op2's sign.
module fadd_sched #(
  parameter int unsigned LAT   = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  fadd_sched_if.slave rq,
  output logic [31:0] fadd_op1,
  output logic [31:0] fadd_op2,
  input  logic [31:0] fadd_result
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(LAT + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [CW-1:0] fifo_cnt     [2];
  logic [IW-1:0] inflight_cnt [2];
  logic [PW-1:0] wr_ptr       [2];
  logic [PW-1:0] rd_ptr       [2];
  logic [31:0]   mem          [2][DEPTH];
  logic          trk_v        [LAT];
  logic          trk_o        [LAT];
  logic          prio;

  logic [1:0]    elig;
  logic [1:0]    issue;
  logic          any_gnt;
  logic          gnt_idx;
  logic [31:0]   sel_op2;
  logic          cap;
  logic          cap_o;
  logic [1:0]    push;
  logic [1:0]    pop;

`ifndef FADD_SCHED_SUB_EN
  logic unused_sub;
  assign unused_sub = ^rq.req_sub;
`endif

  always_comb begin
    // Eligibility is gated by reset so req_ready reads 0 while held in reset.
    for (int unsigned i = 0; i < 2; i++) begin
      elig[i] = reset && rq.req_valid[i] &&
                ((32'(fifo_cnt[i]) + 32'(inflight_cnt[i])) < DEPTH);
    end
    issue   = (elig == 2'b11) ? (prio ? 2'b10 : 2'b01) : elig;
    any_gnt = |issue;
    gnt_idx = issue[1];
    rq.req_ready = issue;

    sel_op2 = rq.req_op2[32*gnt_idx +: 32];
`ifdef FADD_SCHED_SUB_EN
    if (rq.req_sub[gnt_idx]) sel_op2[31] = ~sel_op2[31];
`endif
    fadd_op1 = any_gnt ? rq.req_op1[32*gnt_idx +: 32] : '0;
    fadd_op2 = any_gnt ? sel_op2 : '0;

    cap   = trk_v[LAT-1];
    cap_o = trk_o[LAT-1];
    rq.resp_data = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      push[i]                   = cap && (cap_o == 1'(i));
      pop[i]                    = (fifo_cnt[i] != '0) && rq.resp_ready[i];
      rq.resp_valid[i]          = fifo_cnt[i] != '0;
      rq.resp_data[32*i +: 32]  = mem[i][rd_ptr[i]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= 1'b0;
      for (int unsigned s = 0; s < LAT; s++) begin
        trk_v[s] <= 1'b0;
        trk_o[s] <= 1'b0;
      end
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_cnt[i]     <= '0;
        inflight_cnt[i] <= '0;
        wr_ptr[i]       <= '0;
        rd_ptr[i]       <= '0;
        for (int unsigned d = 0; d < DEPTH; d++) mem[i][d] <= '0;
      end
    end else begin
      trk_v[0] <= any_gnt;
      trk_o[0] <= gnt_idx;
      for (int unsigned s = 1; s < LAT; s++) begin
        trk_v[s] <= trk_v[s-1];
        trk_o[s] <= trk_o[s-1];
      end
      if (any_gnt) prio <= ~gnt_idx;

      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= fadd_result;
          wr_ptr[i]         <= wr_ptr[i] + PW'(1);
        end
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);

        if (push[i] && !pop[i])      fifo_cnt[i] <= fifo_cnt[i] + CW'(1);
        else if (pop[i] && !push[i]) fifo_cnt[i] <= fifo_cnt[i] - CW'(1);

        if (issue[i] && !push[i])      inflight_cnt[i] <= inflight_cnt[i] + IW'(1);
        else if (push[i] && !issue[i]) inflight_cnt[i] <= inflight_cnt[i] - IW'(1);
      end
    end
  end
endmodule
